// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: fixed register numbers, field positions, exception vector,
// sequencer state encoding and the latched exception context.
package cp0_pkg;

    localparam logic [4:0]  BADVADDR_NUM   = 5'd8;
    localparam logic [4:0]  STATUS_NUM     = 5'd12;
    localparam logic [4:0]  CAUSE_NUM      = 5'd13;
    localparam logic [4:0]  EPC_NUM        = 5'd14;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

    localparam int STATUS_EXL    = 1;
    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_CODE_HI = 6;
    localparam int CAUSE_CODE_LO = 2;

    localparam logic [31:0] EXL_MASK = 32'h1 << STATUS_EXL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_X_BADV,
        S_X_EPC,
        S_X_CAUSE,
        S_X_STATUS,
        S_E_EPC,
        S_E_STATUS,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic        badv_vld;
        logic [31:0] badvaddr;
    } exc_ctx_t;

    // EPC points at the branch when the faulting instruction sits in its delay slot.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer: stalls the pipe, walks the CP0 read-modify-write
// sequence one full-word write per cycle, then strobes a PC redirect.
module cp0_exc_seq
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        exc_badv_vld,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_req,
    input  logic        mtc0_req,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    output logic        mtc0_ready,
    output logic        stall,
    output logic        redirect_vld,
    output logic [31:0] redirect_pc,
    output logic [4:0]  cp0_raddr,
    input  logic [31:0] cp0_rdata,
    output logic [4:0]  cp0_waddr,
    output logic [3:0]  cp0_wen,
    output logic [31:0] cp0_wdata
);

    seq_state_t  state, nxt_state;
    exc_ctx_t    ctx;
    logic        exl;
    logic [31:0] target;
    logic        idle;

    assign idle  = (state == S_IDLE);
    assign stall = ~idle;

    // resetn gates the only input-driven path so outputs drop as soon as reset asserts
    assign mtc0_ready = resetn & idle & mtc0_req & ~exc_req & ~eret_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE: begin
                if (exc_req)       nxt_state = exc_badv_vld ? S_X_BADV : S_X_EPC;
                else if (eret_req) nxt_state = S_E_EPC;
            end
            S_X_BADV:   nxt_state = S_X_EPC;
            S_X_EPC:    nxt_state = S_X_CAUSE;
            S_X_CAUSE:  nxt_state = S_X_STATUS;
            S_X_STATUS: nxt_state = S_DONE;
            S_E_EPC:    nxt_state = S_E_STATUS;
            S_E_STATUS: nxt_state = S_DONE;
            S_DONE:     nxt_state = S_IDLE;
            default:    nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctx    <= '0;
            exl    <= 1'b0;
            target <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_req || eret_req) begin
                        ctx.code     <= exc_code;
                        ctx.pc       <= exc_pc;
                        ctx.bd       <= exc_bd;
                        ctx.badv_vld <= exc_badv_vld;
                        ctx.badvaddr <= exc_badvaddr;
                        exl          <= 1'b0;
                    end
                end
                S_X_EPC:    exl    <= cp0_rdata[STATUS_EXL];
                S_X_STATUS: target <= EXC_VECTOR;
                S_E_EPC:    target <= cp0_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        cp0_raddr    = '0;
        cp0_waddr    = '0;
        cp0_wen      = 4'h0;
        cp0_wdata    = '0;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        case (state)
            S_IDLE: begin
                if (mtc0_ready) begin
                    cp0_waddr = mtc0_addr;
                    cp0_wdata = mtc0_data;
                    cp0_wen   = 4'hF;
                end
            end
            S_X_BADV: begin
                cp0_waddr = BADVADDR_NUM;
                cp0_wdata = ctx.badvaddr;
                cp0_wen   = {4{ctx.badv_vld}};
            end
            S_X_EPC: begin
                // Nested exception (EXL already set) keeps the original EPC.
                cp0_raddr = STATUS_NUM;
                if (!cp0_rdata[STATUS_EXL]) begin
                    cp0_waddr = EPC_NUM;
                    cp0_wdata = epc_of(ctx.pc, ctx.bd);
                    cp0_wen   = 4'hF;
                end
            end
            S_X_CAUSE: begin
                cp0_raddr = CAUSE_NUM;
                cp0_waddr = CAUSE_NUM;
                cp0_wdata = {exl ? cp0_rdata[CAUSE_BD] : ctx.bd,
                             cp0_rdata[CAUSE_BD-1:CAUSE_CODE_HI+1],
                             ctx.code,
                             cp0_rdata[CAUSE_CODE_LO-1:0]};
                cp0_wen   = 4'hF;
            end
            S_X_STATUS: begin
                cp0_raddr = STATUS_NUM;
                cp0_waddr = STATUS_NUM;
                cp0_wdata = cp0_rdata | EXL_MASK;
                cp0_wen   = 4'hF;
            end
            S_E_EPC: begin
                cp0_raddr = EPC_NUM;
            end
            S_E_STATUS: begin
                cp0_raddr = STATUS_NUM;
                cp0_waddr = STATUS_NUM;
                cp0_wdata = cp0_rdata & ~EXL_MASK;
                cp0_wen   = 4'hF;
            end
            S_DONE: begin
                redirect_vld = 1'b1;
                redirect_pc  = target;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Randomized bench for cp0_exc_seq with a behavioural CP0 register file and
// a per-request reference model of the expected register updates and redirect.
module tb_cp0_exc_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_req, exc_bd, exc_badv_vld, eret_req, mtc0_req;
    logic [4:0]  exc_code, mtc0_addr;
    logic [31:0] exc_pc, exc_badvaddr, mtc0_data;
    logic        mtc0_ready, stall, redirect_vld;
    logic [31:0] redirect_pc, cp0_rdata, cp0_wdata;
    logic [4:0]  cp0_raddr, cp0_waddr;
    logic [3:0]  cp0_wen;

    logic [31:0] rf [32];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_a = '0;
    logic [31:0] pl_d = '0;
    int          wcnt = 0;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    cp0_exc_seq dut (
        .clk(clk), .resetn(resetn),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .exc_badv_vld(exc_badv_vld), .exc_badvaddr(exc_badvaddr),
        .eret_req(eret_req), .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr),
        .mtc0_data(mtc0_data), .mtc0_ready(mtc0_ready), .stall(stall),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .cp0_waddr(cp0_waddr),
        .cp0_wen(cp0_wen), .cp0_wdata(cp0_wdata)
    );

    // Register file: any nonzero mask writes the whole word, masked-off bytes as zero.
    assign cp0_rdata = rf[cp0_raddr];
    always @(posedge clk) begin
        if (pl_en) rf[pl_a] <= pl_d;
        if (cp0_wen != 4'h0) begin
            if (cp0_waddr != 5'd0)
                rf[cp0_waddr] <= {cp0_wen[3] ? cp0_wdata[31:24] : 8'h00,
                                  cp0_wen[2] ? cp0_wdata[23:16] : 8'h00,
                                  cp0_wen[1] ? cp0_wdata[15:8]  : 8'h00,
                                  cp0_wen[0] ? cp0_wdata[7:0]   : 8'h00};
            if (stall) wcnt <= wcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic preload4(input logic [31:0] bv, input logic [31:0] st,
                            input logic [31:0] ca, input logic [31:0] ep);
        preload(5'd8, bv); preload(5'd12, st); preload(5'd13, ca); preload(5'd14, ep);
    endtask

    // Drives one exception/ERET request and checks it against the architectural model.
    task automatic run_req(input bit is_exc, input bit is_eret, input bit hold_mtc0,
                           input logic [4:0] code, input logic [31:0] pc, input bit bd,
                           input bit bv, input logic [31:0] badv);
        logic [31:0] st, ca, ep, bvr, exp_pc;
        bit          x;
        int          lat, nw, w0, got;
        st = rf[12]; ca = rf[13]; ep = rf[14]; bvr = rf[8];
        if (is_exc) begin
            x   = st[1];
            if (bv) bvr = badv;
            if (!x) ep = bd ? pc - 32'd4 : pc;
            ca  = {x ? ca[31] : bd, ca[30:7], code, ca[1:0]};
            st  = st | 32'h2;
            exp_pc = 32'hBFC00380;
            lat = bv ? 5 : 4;
            nw  = (bv ? 1 : 0) + (x ? 0 : 1) + 2;
        end else begin
            exp_pc = ep;
            st  = st & ~32'h2;
            lat = 3;
            nw  = 1;
        end
        w0 = wcnt;
        @(negedge clk);
        exc_req = is_exc; eret_req = is_eret; mtc0_req = hold_mtc0;
        mtc0_addr = 5'd12; mtc0_data = 32'h1;
        exc_code = code; exc_pc = pc; exc_bd = bd; exc_badv_vld = bv; exc_badvaddr = badv;
        #1;
        check("c0_ready", mtc0_ready, 1'b0);
        check("c0_stall", stall, 1'b0);
        got = 0;
        for (int c = 1; c <= 8 && got == 0; c++) begin
            @(negedge clk);
            exc_req = 1'b0; eret_req = 1'b0;
            exc_code = 5'($urandom); exc_pc = $urandom; exc_bd = 1'($urandom);
            exc_badv_vld = 1'($urandom); exc_badvaddr = $urandom;
            #1;
            check("busy_stall", stall, 1'b1);
            if (hold_mtc0) check("busy_ready", mtc0_ready, 1'b0);
            if (redirect_vld) begin
                got = c;
                check("redirect_pc", redirect_pc, exp_pc);
            end
        end
        check("latency", got, lat);
        @(negedge clk); #1;
        check("idle_stall", stall, 1'b0);
        check("idle_redirect", redirect_vld, 1'b0);
        if (hold_mtc0) begin
            check("post_ready", mtc0_ready, 1'b1);
            check("post_wen", cp0_wen, 4'hF);
            @(negedge clk);
            mtc0_req = 1'b0;
            st = 32'h1;
        end
        check("badvaddr", rf[8], bvr);
        check("epc", rf[14], ep);
        check("cause", rf[13], ca);
        check("status", rf[12], st);
        check("nwrites", wcnt - w0, nw);
    endtask

    task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        mtc0_req = 1'b1; mtc0_addr = a; mtc0_data = d;
        #1;
        check("mtc0_ready", mtc0_ready, 1'b1);
        check("mtc0_wen", cp0_wen, 4'hF);
        check("mtc0_waddr", cp0_waddr, a);
        check("mtc0_wdata", cp0_wdata, d);
        @(negedge clk);
        mtc0_req = 1'b0;
        #1;
        if (a != 5'd0) check("mtc0_reg", rf[a], d);
        check("mtc0_stall", stall, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        exc_req = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_badv_vld = 0; exc_badvaddr = 0;
        eret_req = 0; mtc0_req = 1; mtc0_addr = 5'd3; mtc0_data = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_ready", mtc0_ready, 1'b0);
        check("rst_wen", cp0_wen, 4'h0);
        check("rst_redirect", redirect_vld, 1'b0);
        check("rst_rpc", redirect_pc, 32'h0);
        @(negedge clk);
        mtc0_req = 1'b0;
        resetn = 1'b1;

        // Directed cases
        preload4(32'h0, 32'h0000FF00, 32'h0, 32'h0);
        run_req(1, 0, 0, 5'h04, 32'h80001000, 0, 1, 32'h12345677);
        check("tp1_status", rf[12], 32'h0000FF02);
        check("tp1_code", rf[13][6:2], 5'h04);

        preload4(32'h0, 32'h0000FF00, 32'h0, 32'h0);
        run_req(1, 0, 0, 5'h0A, 32'h80002004, 1, 0, 32'h0);
        check("tp2_epc", rf[14], 32'h80002000);
        check("tp2_bd", rf[13][31], 1'b1);

        preload4(32'h0, 32'h00000002, 32'h0000_0100, 32'h8000_0ABC);
        run_req(1, 0, 0, 5'h08, 32'h80004004, 1, 0, 32'h0);
        check("tp3_status", rf[12], 32'h00000002);
        check("tp3_epc", rf[14], 32'h8000_0ABC);

        preload4(32'h0, 32'h0000FF03, 32'h0, 32'h80003000);
        run_req(0, 1, 0, 5'h0, 32'h0, 0, 0, 32'h0);
        check("tp4_status", rf[12], 32'h0000FF01);

        preload4(32'h0, 32'h0000FF00, 32'h0, 32'h0);
        run_req(1, 1, 1, 5'h0C, 32'h80005000, 0, 0, 32'h0);

        // Reset during X_CAUSE: EPC write stands, Cause untouched, no redirect.
        preload4(32'h0, 32'h0, 32'h0000_0055, 32'h0);
        @(negedge clk);
        exc_req = 1'b1; exc_code = 5'h05; exc_pc = 32'h80006000; exc_bd = 1'b0; exc_badv_vld = 1'b0;
        @(negedge clk);
        exc_req = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mrst_stall", stall, 1'b0);
        check("mrst_wen", cp0_wen, 4'h0);
        check("mrst_waddr", cp0_waddr, 5'h0);
        check("mrst_raddr", cp0_raddr, 5'h0);
        check("mrst_wdata", cp0_wdata, 32'h0);
        check("mrst_redirect", redirect_vld, 1'b0);
        check("mrst_rpc", redirect_pc, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check("mrst_idle_stall", stall, 1'b0);
            check("mrst_idle_redir", redirect_vld, 1'b0);
        end
        check("mrst_epc", rf[14], 32'h80006000);
        check("mrst_cause", rf[13], 32'h0000_0055);
        check("mrst_status", rf[12], 32'h0);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            int k;
            preload4($urandom, $urandom, $urandom, $urandom);
            k = $urandom_range(0, 9);
            if (k <= 4)
                run_req(1, 1'($urandom), 0, 5'($urandom), $urandom, 1'($urandom),
                        1'($urandom), $urandom);
            else if (k <= 7)
                run_req(0, 1, 0, 5'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
            else
                do_mtc0(5'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
        $finish;
    end

endmodule
